// File: rtl/unidade_busca_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   estado_busca_t : fetch FSM states (REQ, FULL, DRAIN)
//   NOP            : value presented on dado when nothing is buffered
//   INCR_PC        : sequential program-counter increment
//   LARG_FILA      : width of one buffer entry, {instr, pc4}
//   prox_pc()      : next sequential address, modulo 2^32
package pacote_busca;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        FULL  = 2'd1,
        DRAIN = 2'd2
    } estado_busca_t;

    localparam logic [31:0] NOP       = 32'h0;
    localparam logic [31:0] INCR_PC   = 32'd4;
    localparam int          LARG_FILA = 64;

    // Sequential successor of an address; wraps naturally at 2^32.
    function automatic logic [31:0] prox_pc(input logic [31:0] endereco);
        return endereco + INCR_PC;
    endfunction

endpackage

// File: rtl/unidade_busca_fila.sv
// fila_busca: two-entry FIFO that buffers fetched {instr, pc4} pairs.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   push, din    : write din at the tail (ignored when full and not popping)
//   pop          : drop the head entry (ignored when empty)
//   flush        : empty the FIFO; wins over push and pop
//   head         : oldest entry, all zeros while empty
//   cnt          : occupancy, 0..2
module fila_busca #(
    parameter int W = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   cnt
);

    logic [W-1:0] mem_r [2];
    logic         rd_ptr_r;
    logic         wr_ptr_r;
    logic [1:0]   cnt_r;
    logic         do_push_s;
    logic         do_pop_s;

    // Qualify requests against occupancy; a full FIFO accepts a push only alongside a pop.
    always_comb begin
        do_pop_s  = pop && (cnt_r != 2'd0);
        do_push_s = push && ((cnt_r != 2'd2) || do_pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            cnt_r    <= 2'd0;
        end else if (flush) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            cnt_r    <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            cnt_r <= cnt_r + {1'b0, do_push_s} - {1'b0, do_pop_s};
        end
    end

    // Head is read straight from storage registers; forced to zero when empty.
    always_comb begin
        if (cnt_r != 2'd0) begin
            head = mem_r[rd_ptr_r];
        end else begin
            head = '0;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/unidade_busca.sv
// unidade_busca: instruction-fetch stage.
// Owns the PC, fetches over a req/ack handshake, buffers up to two
// instructions and presents the oldest one to IF/ID.
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   stall                 : IF/ID held, head is not consumed
//   desvio, alvo          : taken branch/jump and its target (flush + redirect)
//   imem_req, imem_addr   : fetch request and address (registered)
//   imem_ack, imem_rdata  : fetch response
//   dado, pc4             : head instruction and its address + 4
//   bolha                 : no valid head, IF/ID loads a bubble
module unidade_busca
    import pacote_busca::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        desvio,
    input  logic [31:0] alvo,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dado,
    output logic [31:0] pc4,
    output logic        bolha
);

    estado_busca_t        estado_r;
    estado_busca_t        estado_prox_s;
    logic [31:0]          pc_r;
    logic [31:0]          pc_prox_s;
    logic                 req_r;
    logic [31:0]          addr_r;
    logic                 consume_s;
    logic                 push_s;
    logic [1:0]           cnt_s;
    logic [LARG_FILA-1:0] head_s;

    // Next-state, next-PC and buffer push decisions; desvio overrides everything.
    always_comb begin
        consume_s     = (cnt_s != 2'd0) && !stall && !desvio;
        push_s        = 1'b0;
        estado_prox_s = estado_r;
        pc_prox_s     = pc_r;
        if (desvio) begin
            pc_prox_s = alvo;
            // An outstanding request with no ack yet must be drained before the target is fetched.
            if ((estado_r != FULL) && !imem_ack) begin
                estado_prox_s = DRAIN;
            end else begin
                estado_prox_s = REQ;
            end
        end else begin
            case (estado_r)
                REQ: begin
                    if (imem_ack) begin
                        push_s    = 1'b1;
                        pc_prox_s = prox_pc(pc_r);
                        if (({1'b0, cnt_s} + 3'd1 - {2'b00, consume_s}) == 3'd2) begin
                            estado_prox_s = FULL;
                        end else begin
                            estado_prox_s = REQ;
                        end
                    end else begin
                        estado_prox_s = REQ;
                    end
                end
                FULL: begin
                    if (consume_s) begin
                        estado_prox_s = REQ;
                    end else begin
                        estado_prox_s = FULL;
                    end
                end
                DRAIN: begin
                    // The stale response is dropped; pc already holds the target.
                    if (imem_ack) begin
                        estado_prox_s = REQ;
                    end else begin
                        estado_prox_s = DRAIN;
                    end
                end
                default: begin
                    estado_prox_s = REQ;
                end
            endcase
        end
    end

    // FSM, PC and registered memory-request outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_r <= REQ;
            pc_r     <= RESET_PC;
            req_r    <= 1'b1;
            addr_r   <= RESET_PC;
        end else begin
            estado_r <= estado_prox_s;
            pc_r     <= pc_prox_s;
            req_r    <= (estado_prox_s != FULL);
            // DRAIN keeps the abandoned address on the bus until its ack.
            if (estado_prox_s == DRAIN) begin
                addr_r <= addr_r;
            end else begin
                addr_r <= pc_prox_s;
            end
        end
    end

    fila_busca #(
        .W (LARG_FILA)
    ) u_fila (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .pop   (consume_s),
        .flush (desvio),
        .din   ({imem_rdata, prox_pc(pc_r)}),
        .head  (head_s),
        .cnt   (cnt_s)
    );

    assign imem_req  = req_r;
    assign imem_addr = addr_r;
    assign dado      = head_s[63:32];
    assign pc4       = head_s[31:0];
    assign bolha     = (cnt_s == 2'd0);

endmodule

// File: tb/tb_unidade_busca.sv
// Self-checking bench for unidade_busca: a queue-based reference model of the
// fetch buffer plus a latency-configurable instruction memory, directed
// scenarios with literal expectations, then a randomized run.
module tb_unidade_busca;

    localparam logic [31:0] RPC = 32'h0000_0040;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        desvio;
    logic [31:0] alvo;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] dado;
    logic [31:0] pc4;
    logic        bolha;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] q_i[$];
    logic [31:0] q_p[$];
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_daddr;

    // Memory model state
    int  wait_c;
    int  lat_cur;
    int  lat_fixed;
    bit  cur_req;

    unidade_busca #(.RESET_PC(RPC)) dut (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .desvio     (desvio),
        .alvo       (alvo),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dado       (dado),
        .pc4        (pc4),
        .bolha      (bolha)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h40:  rom = 32'h11;
            32'h44:  rom = 32'h22;
            32'h48:  rom = 32'h33;
            default: rom = {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
        endcase
    endfunction

    function automatic int pick_lat();
        if (lat_fixed >= 0) return lat_fixed;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nome, act, exp, $time);
        end
    endtask

    // Model outputs derived from buffer contents and the pending-discard flag.
    task automatic compare_all();
        bit          e_req;
        logic [31:0] e_addr;
        e_req  = m_pend || (q_i.size() < 2);
        e_addr = m_pend ? m_daddr : m_pc;
        chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
        if (e_req) chk("imem_addr", imem_addr, e_addr);
        chk("dado",  dado, (q_i.size() > 0) ? q_i[0] : 32'h0);
        chk("pc4",   pc4,  (q_p.size() > 0) ? q_p[0] : 32'h0);
        chk("bolha", {31'b0, bolha}, {31'b0, (q_i.size() == 0)});
    endtask

    task automatic model_step();
        bit          mreq;
        logic [31:0] maddr;
        bit          cons;
        mreq  = m_pend || (q_i.size() < 2);
        maddr = m_pend ? m_daddr : m_pc;
        cons  = (q_i.size() > 0) && !stall && !desvio;
        if (desvio) begin
            if (mreq && !imem_ack) begin
                m_pend  = 1'b1;
                m_daddr = maddr;
            end else begin
                m_pend = 1'b0;
            end
            q_i.delete();
            q_p.delete();
            m_pc = alvo;
        end else begin
            if (cons) begin
                void'(q_i.pop_front());
                void'(q_p.pop_front());
            end
            if (imem_ack && mreq) begin
                if (m_pend) begin
                    m_pend = 1'b0;
                end else begin
                    q_i.push_back(imem_rdata);
                    q_p.push_back(m_pc + 32'd4);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic mem_step();
        if (cur_req) begin
            if (imem_ack) begin
                wait_c  = 0;
                lat_cur = pick_lat();
            end else begin
                wait_c++;
            end
        end else begin
            wait_c = 0;
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance models, compare.
    task automatic step(input logic st, input logic dv, input logic [31:0] al);
        stall   = st;
        desvio  = dv;
        alvo    = al;
        cur_req = imem_req;
        imem_ack   = cur_req && (wait_c >= lat_cur);
        imem_rdata = imem_ack ? rom(imem_addr) : $urandom;
        @(posedge clock);
        model_step();
        mem_step();
        #1;
        compare_all();
    endtask

    task automatic model_reset();
        q_i.delete();
        q_p.delete();
        m_pc    = RPC;
        m_pend  = 1'b0;
        wait_c  = 0;
        lat_cur = pick_lat();
    endtask

    task automatic finish_reset();
        stall    = 1'b0;
        desvio   = 1'b0;
        imem_ack = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        compare_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset      = 1'b1;
        stall      = 1'b0;
        desvio     = 1'b0;
        alvo       = 32'h0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        lat_fixed  = 0;
        cur_req    = 1'b0;
        finish_reset();

        // Reset state and zero-wait sequential fetch from 0x40
        chk("rst_addr",  imem_addr, 32'h40);
        chk("rst_req",   {31'b0, imem_req}, 32'h1);
        chk("rst_bolha", {31'b0, bolha}, 32'h1);
        chk("rst_dado",  dado, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("seq1_dado", dado, 32'h11);
        chk("seq1_pc4",  pc4, 32'h44);
        chk("seq1_addr", imem_addr, 32'h44);
        chk("seq1_bolha", {31'b0, bolha}, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("seq2_dado", dado, 32'h22);
        chk("seq2_pc4",  pc4, 32'h48);
        chk("seq2_addr", imem_addr, 32'h48);
        step(1'b0, 1'b0, 32'h0);
        chk("seq3_dado", dado, 32'h33);
        chk("seq3_pc4",  pc4, 32'h4C);

        // Stall 5 cycles: buffer fills, request stops, head holds
        repeat (5) step(1'b1, 1'b0, 32'h0);
        chk("stall_req",  {31'b0, imem_req}, 32'h0);
        chk("stall_dado", dado, 32'h33);
        chk("stall_pc4",  pc4, 32'h4C);
        step(1'b0, 1'b0, 32'h0);
        chk("rel1_dado", dado, rom(32'h4C));
        chk("rel1_pc4",  pc4, 32'h50);
        chk("rel1_addr", imem_addr, 32'h50);
        step(1'b0, 1'b0, 32'h0);
        chk("rel2_pc4",  pc4, 32'h54);

        // desvio coinciding with ack and stall
        step(1'b1, 1'b1, 32'h200);
        chk("dvack_addr",  imem_addr, 32'h200);
        chk("dvack_bolha", {31'b0, bolha}, 32'h1);

        // Sequential wrap at the top of the address space
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_pc4",  pc4, 32'h0);
        chk("wrap_dado", dado, rom(32'hFFFF_FFFC));
        chk("wrap_addr", imem_addr, 32'h0);

        // Redirect while a latency-3 request to 0x20 is pending
        lat_fixed = 3;
        lat_cur   = 3;
        step(1'b0, 1'b1, 32'h20);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (imem_req && imem_addr == 32'h20) found = 1'b1;
            else step(1'b0, 1'b0, 32'h0);
        end
        chk("reach_0x20", {31'b0, found}, 32'h1);
        step(1'b0, 1'b1, 32'h100);
        chk("drain_hold", imem_addr, 32'h20);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (imem_addr != 32'h20) found = 1'b1;
            else step(1'b0, 1'b0, 32'h0);
        end
        chk("drain_next_addr", imem_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (!bolha) found = 1'b1;
            else step(1'b0, 1'b0, 32'h0);
        end
        chk("redir_arrived", {31'b0, found}, 32'h1);
        chk("redir_dado", dado, rom(32'h100));
        chk("redir_pc4",  pc4, 32'h104);

        // Ack latency 2, no stall
        lat_fixed = 2;
        lat_cur   = 2;
        step(1'b0, 1'b1, 32'h300);
        repeat (12) step(1'b0, 1'b0, 32'h0);

        // Async reset while draining a request, with pc at the wrap point
        lat_fixed = 3;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (imem_req && wait_c == 0) found = 1'b1;
            else step(1'b0, 1'b0, 32'h0);
        end
        chk("fresh_req", {31'b0, found}, 32'h1);
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_addr",  imem_addr, RPC);
        chk("arst_req",   {31'b0, imem_req}, 32'h1);
        chk("arst_bolha", {31'b0, bolha}, 32'h1);
        chk("arst_pc4",   pc4, 32'h0);
        lat_fixed = 0;
        finish_reset();

        // Async reset with a full buffer clears the head immediately
        repeat (3) step(1'b1, 1'b0, 32'h0);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_full_dado",  dado, 32'h0);
        chk("arst_full_bolha", {31'b0, bolha}, 32'h1);
        finish_reset();

        // Randomized run
        lat_fixed = -1;
        lat_cur   = pick_lat();
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00})
                                            : $urandom;
            step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
